// File: rtl/wb_bridge_pkg.sv
// Shared types for the Wishbone-to-Ibex device bridge.
package wb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    RESP,
    DRAIN
  } wb_br_state_e;

  localparam int unsigned TimeoutCyclesDef = 255;

endpackage

// File: rtl/wb_ibex_device_bridge.sv
// Wishbone B4 pipelined slave that issues one Ibex-style device request
// per bus cycle and returns the device response as ack/err.
module wb_ibex_device_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned AddressWidth  = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = TimeoutCyclesDef,
  parameter int unsigned TimeoutW      = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [AddressWidth-1:0]  wb_addr_i,
  input  logic [DataWidth-1:0]     wb_data_i,
  input  logic [DataWidth/8-1:0]   wb_sel_i,
  output logic                     wb_stall_o,
  output logic                     wb_ack_o,
  output logic [DataWidth-1:0]     wb_data_o,
  output logic                     wb_err_o,
  output logic                     device_req_o,
  output logic [AddressWidth-1:0]  device_addr_o,
  output logic                     device_we_o,
  output logic [DataWidth/8-1:0]   device_be_o,
  output logic [DataWidth-1:0]     device_wdata_o,
  input  logic                     device_rvalid_i,
  input  logic [DataWidth-1:0]     device_rdata_i,
  input  logic                     device_err_i
);

  wb_br_state_e r_state;

  logic [TimeoutW-1:0]     r_cnt;
  logic                    r_we;
  logic [AddressWidth-1:0] r_addr;
  logic [DataWidth-1:0]    r_wdata;
  logic [DataWidth/8-1:0]  r_sel;
  logic                    r_req;
  logic                    r_stall;
  logic                    r_ack;
  logic                    r_err;
  logic [DataWidth-1:0]    r_rdata;

  logic [TimeoutW-1:0]  w_cnt_inc;
  logic [TimeoutW-1:0]  w_cnt_sat;
  logic                 w_tmo;
  logic [DataWidth-1:0] w_rd;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_cnt_sat = (&r_cnt) ? r_cnt : w_cnt_inc;
  // Timeout fires on the cycle the counter would reach the limit.
  assign w_tmo = (TimeoutCycles != 0) &&
                 (w_cnt_inc == TimeoutW'(TimeoutCycles));
  assign w_rd = r_we ? '0 : device_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_req   <= 1'b0;
      r_stall <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_req   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      unique case (r_state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            r_we    <= wb_we_i;
            r_addr  <= wb_addr_i;
            r_wdata <= wb_data_i;
            r_sel   <= wb_sel_i;
            r_req   <= 1'b1;
            r_stall <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ, WAIT: begin
          if (!wb_cyc_i) begin
            // Abandoned cycle: a response already here needs no draining.
            if (device_rvalid_i) begin
              r_stall <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_cnt   <= '0;
              r_state <= DRAIN;
            end
          end else if (device_rvalid_i) begin
            r_ack   <= !device_err_i;
            r_err   <= device_err_i;
            r_rdata <= w_rd;
            r_state <= RESP;
          end else if (r_state == REQ) begin
            r_cnt   <= '0;
            r_state <= WAIT;
          end else if (w_tmo) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_cnt <= w_cnt_sat;
          end
        end
        RESP: begin
          r_stall <= 1'b0;
          r_state <= IDLE;
        end
        DRAIN: begin
          if (device_rvalid_i || w_tmo) begin
            r_stall <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= w_cnt_sat;
          end
        end
        default: begin
          r_stall <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign wb_stall_o     = r_stall;
  assign wb_ack_o       = r_ack;
  assign wb_err_o       = r_err;
  assign wb_data_o      = r_rdata;
  assign device_req_o   = r_req;
  assign device_addr_o  = r_addr;
  assign device_we_o    = r_we;
  assign device_be_o    = r_sel;
  assign device_wdata_o = r_wdata;

endmodule

// File: tb/tb_wb_ibex_device_bridge.sv
// Randomized self-checking bench for wb_ibex_device_bridge.
// Expected timing comes from a latency-based transaction model.
module tb_wb_ibex_device_bridge;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdat;
  logic [SW-1:0] sel;
  logic          stall, ack, err;
  logic [DW-1:0] rdat_o;
  logic          dreq, dwe;
  logic [AW-1:0] daddr;
  logic [SW-1:0] dbe;
  logic [DW-1:0] dwdata;
  logic          rvalid, derr;
  logic [DW-1:0] drdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_ibex_device_bridge #(
    .AddressWidth (AW),
    .DataWidth    (DW),
    .TimeoutCycles(TMO),
    .TimeoutW     (3)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .wb_cyc_i       (cyc),
    .wb_stb_i       (stb),
    .wb_we_i        (we),
    .wb_addr_i      (addr),
    .wb_data_i      (wdat),
    .wb_sel_i       (sel),
    .wb_stall_o     (stall),
    .wb_ack_o       (ack),
    .wb_data_o      (rdat_o),
    .wb_err_o       (err),
    .device_req_o   (dreq),
    .device_addr_o  (daddr),
    .device_we_o    (dwe),
    .device_be_o    (dbe),
    .device_wdata_o (dwdata),
    .device_rvalid_i(rvalid),
    .device_rdata_i (drdata),
    .device_err_i   (derr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdat = '0; sel = '0;
    rvalid = 1'b0; derr = 1'b0; drdata = '0;
    step();
    step();
    @(negedge clk);
    vectors++;
    if ({dreq, ack, err, stall, dwe} !== 5'b0 || daddr !== '0 ||
        dbe !== '0 || dwdata !== '0 || rdat_o !== '0) begin
      miscompares++;
      $display("FAIL reset: req=%b ack=%b err=%b stall=%b addr=%h data=%h want all 0",
               dreq, ack, err, stall, daddr, rdat_o);
    end
    rst = 1'b0;
    step();
  endtask

  // lat: cycles from device_req to rvalid (0 = same cycle); <0 = silent
  task automatic do_txn(input string nm, input logic t_we,
                        input logic [AW-1:0] t_addr, input logic [DW-1:0] t_wd,
                        input logic [SW-1:0] t_sel, input int lat,
                        input logic t_derr, input logic [DW-1:0] t_rd);
    bit      tmo;
    int      done;
    logic    e_err;
    logic [DW-1:0] e_data;
    logic [3:0] e_ctl;
    tmo    = (lat < 0) || (lat > TMO);
    done   = tmo ? 2 + TMO : 2 + lat;
    e_err  = tmo ? 1'b1 : t_derr;
    e_data = (tmo || t_we) ? '0 : t_rd;
    cyc = 1'b1; stb = 1'b1; we = t_we;
    addr = t_addr; wdat = t_wd; sel = t_sel;
    @(negedge clk);
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++;
      $display("FAIL %s accept_stall: got %b want 0", nm, stall);
    end
    step();
    stb = 1'b0;
    for (int k = 1; k <= done + 1; k++) begin
      if (!tmo && k == 1 + lat) begin
        rvalid = 1'b1; derr = t_derr; drdata = t_rd;
      end else begin
        rvalid = 1'b0; derr = 1'b0; drdata = $urandom;
      end
      @(negedge clk);
      e_ctl = {k == 1, (k == done) && !e_err, (k == done) && e_err, k <= done};
      vectors++;
      if ({dreq, ack, err, stall} !== e_ctl) begin
        miscompares++;
        $display("FAIL %s cyc%0d req/ack/err/stall: got %b want %b",
                 nm, k, {dreq, ack, err, stall}, e_ctl);
      end
      if (k == 1) begin
        vectors++;
        if (daddr !== t_addr || dwe !== t_we || dbe !== t_sel || dwdata !== t_wd) begin
          miscompares++;
          $display("FAIL %s devreq: got a=%h we=%b be=%b wd=%h want a=%h we=%b be=%b wd=%h",
                   nm, daddr, dwe, dbe, dwdata, t_addr, t_we, t_sel, t_wd);
        end
      end
      if (k == done) begin
        vectors++;
        if (rdat_o !== e_data) begin
          miscompares++;
          $display("FAIL %s rdata: got %h want %h", nm, rdat_o, e_data);
        end
      end
      step();
    end
    rvalid = 1'b0; derr = 1'b0; cyc = 1'b0;
  endtask

  task automatic test_read();
    do_txn("read", 1'b0, 32'h0000_1000, 32'h0, 4'hF, 1, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic test_write();
    do_txn("write", 1'b1, 32'h8000_1004, 32'h0000_55AA, 4'b0011, 1, 1'b0, 32'h1234_5678);
  endtask

  task automatic test_err();
    do_txn("deverr", 1'b0, 32'h0000_2000, 32'h0, 4'hF, 2, 1'b1, 32'hCAFE_0001);
  endtask

  task automatic test_timeout();
    do_txn("timeout", 1'b0, 32'h0000_3000, 32'h0, 4'hF, -1, 1'b0, 32'h0);
    do_txn("after_tmo", 1'b0, 32'h0000_3004, 32'h0, 4'hF, 0, 1'b0, 32'hA5A5_0F0F);
  endtask

  task automatic test_abort();
    logic [7:0] e_stall;
    e_stall = 8'b0011_1110;
    for (int k = 0; k < 8; k++) begin
      cyc = (k < 2); stb = (k == 0); we = 1'b0;
      addr = 32'h0000_4000; sel = 4'hF;
      rvalid = (k == 5); drdata = 32'hBAD0_BAD0; derr = 1'b0;
      @(negedge clk);
      vectors++;
      if ({dreq, ack, err, stall} !== {k == 1, 1'b0, 1'b0, e_stall[k]}) begin
        miscompares++;
        $display("FAIL abort cyc%0d req/ack/err/stall: got %b want %b",
                 k, {dreq, ack, err, stall}, {k == 1, 1'b0, 1'b0, e_stall[k]});
      end
      step();
    end
    rvalid = 1'b0;
    do_txn("after_abort", 1'b0, 32'h0000_4004, 32'h0, 4'hF, 1, 1'b0, 32'h0BAD_F00D);
  endtask

  task automatic test_back_to_back();
    logic [6:0] e_req, e_ack, e_stall;
    logic [DW-1:0] ra, rb;
    ra = $urandom; rb = $urandom;
    e_req = 7'b001_0010; e_ack = 7'b010_0100; e_stall = 7'b011_0110;
    for (int k = 0; k < 7; k++) begin
      cyc = (k < 6); stb = (k < 4); we = 1'b0; sel = 4'hF;
      addr = (k == 0) ? 32'h0000_5000 : 32'h0000_5004;
      rvalid = (k == 1) || (k == 4);
      drdata = (k == 1) ? ra : rb; derr = 1'b0;
      @(negedge clk);
      vectors++;
      if ({dreq, ack, err, stall} !== {e_req[k], e_ack[k], 1'b0, e_stall[k]}) begin
        miscompares++;
        $display("FAIL b2b cyc%0d req/ack/err/stall: got %b want %b",
                 k, {dreq, ack, err, stall}, {e_req[k], e_ack[k], 1'b0, e_stall[k]});
      end
      if (k == 1 || k == 4) begin
        vectors++;
        if (daddr !== ((k == 1) ? 32'h0000_5000 : 32'h0000_5004)) begin
          miscompares++;
          $display("FAIL b2b cyc%0d addr: got %h", k, daddr);
        end
      end
      if (k == 2 || k == 5) begin
        vectors++;
        if (rdat_o !== ((k == 2) ? ra : rb)) begin
          miscompares++;
          $display("FAIL b2b cyc%0d rdata: got %h want %h", k, rdat_o, (k == 2) ? ra : rb);
        end
      end
      step();
    end
    rvalid = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 8; k++) begin
      cyc = (k < 3); stb = (k == 0); we = 1'b1; sel = 4'hC;
      addr = 32'h0000_6000; wdat = 32'h7777_8888;
      rst = (k == 2);
      rvalid = (k == 4); derr = 1'b0; drdata = 32'h1111_2222;
      @(negedge clk);
      if (k == 3) begin
        vectors++;
        if ({dreq, ack, err, stall, dwe} !== 5'b0 || daddr !== '0 ||
            dbe !== '0 || dwdata !== '0 || rdat_o !== '0) begin
          miscompares++;
          $display("FAIL rst_mid outputs: req=%b ack=%b err=%b stall=%b we=%b addr=%h want all 0",
                   dreq, ack, err, stall, dwe, daddr);
        end
      end else if (k > 3) begin
        vectors++;
        if ({dreq, ack, err, stall} !== 4'b0) begin
          miscompares++;
          $display("FAIL rst_mid cyc%0d late rvalid: got %b want 0000",
                   k, {dreq, ack, err, stall});
        end
      end
      step();
    end
    rst = 1'b0; rvalid = 1'b0;
    do_txn("after_rst", 1'b0, 32'h0000_6004, 32'h0, 4'hF, 3, 1'b0, 32'h5566_7788);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int lat;
      lat = int'($urandom_range(0, TMO + 1));
      if (lat > TMO) lat = -1;
      do_txn("rand", 1'($urandom_range(0, 1)), $urandom, $urandom,
             4'($urandom), lat, ($urandom_range(0, 3) == 0), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_err();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
